// File: rtl/multicycle_control_fsm_if.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_control_fsm_if
//  Purpose  : Bundle of datapath status inputs and control outputs exchanged
//             between the multicycle control sequencer and the MIPS datapath.
//  Revision : 1.0 - initial release
// ============================================================================
interface multicycle_control_fsm_if;
    // Datapath status into the sequencer
    logic [5:0] Opcode;
    logic       Zero;
    logic       MemReady;

    // Control outputs to the datapath
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSrc;
    logic       PCEn;
    logic       InstrDone;
    logic       IllegalOp;
    logic [3:0] State;

    // Sequencer side
    modport slave (
        input  Opcode, Zero, MemReady,
        output IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCEn, InstrDone, IllegalOp, State
    );

    // Datapath side
    modport master (
        output Opcode, Zero, MemReady,
        input  IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCEn, InstrDone, IllegalOp, State
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_control_fsm
//  Purpose  : Moore-style control sequencer for a multicycle MIPS datapath.
//             Steps R-type, lw, sw, beq, addi and j through fetch, decode,
//             execute, memory and writeback; stalls on MemReady.
//  Revision : 1.0 - initial release
// ============================================================================
module multicycle_control_fsm (
    input  wire logic               clk,
    input  wire logic               rst_n,
    multicycle_control_fsm_if.slave bus
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_J     = 6'b000010;

    state_t     r_state;
    state_t     w_next_state;
    logic       r_illegal;

    logic       w_iord;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_dst;
    logic       w_memto_reg;
    logic       w_reg_write;
    logic       w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_alu_op;
    logic [1:0] w_pc_src;
    logic       w_pc_write;
    logic       w_branch;
    logic       w_instr_done;
    logic       w_set_illegal;

    // State register; reset parks the sequencer in FETCH immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Sticky unsupported-opcode flag, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal <= 1'b0;
        end else if (w_set_illegal) begin
            r_illegal <= 1'b1;
        end
    end

    // Next-state and raw control decode from the current state
    always_comb begin
        w_next_state  = S_FETCH;
        w_iord        = 1'b0;
        w_mem_read    = 1'b0;
        w_mem_write   = 1'b0;
        w_ir_write    = 1'b0;
        w_reg_dst     = 1'b0;
        w_memto_reg   = 1'b0;
        w_reg_write   = 1'b0;
        w_alu_src_a   = 1'b0;
        w_alu_src_b   = 2'b00;
        w_alu_op      = 2'b00;
        w_pc_src      = 2'b00;
        w_pc_write    = 1'b0;
        w_branch      = 1'b0;
        w_instr_done  = 1'b0;
        w_set_illegal = 1'b0;
        case (r_state)
            S_FETCH: begin
                // PC+4 is computed every fetch cycle but only committed
                // together with the instruction word when memory is ready
                w_mem_read   = 1'b1;
                w_alu_src_b  = 2'b01;
                w_ir_write   = bus.MemReady;
                w_pc_write   = bus.MemReady;
                w_next_state = bus.MemReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Branch target precomputed into ALUOut while decoding
                w_alu_src_b = 2'b11;
                case (bus.Opcode)
                    c_OP_LW,
                    c_OP_SW:    w_next_state = S_MEMADR;
                    c_OP_RTYPE: w_next_state = S_EXECUTE;
                    c_OP_BEQ:   w_next_state = S_BRANCH;
                    c_OP_ADDI:  w_next_state = S_ADDIEX;
                    c_OP_J:     w_next_state = S_JUMP;
                    default: begin
                        w_next_state  = S_FETCH;
                        w_set_illegal = 1'b1;
                        w_instr_done  = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                w_alu_src_a  = 1'b1;
                w_alu_src_b  = 2'b10;
                w_next_state = (bus.Opcode == c_OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                w_iord       = 1'b1;
                w_mem_read   = 1'b1;
                w_next_state = bus.MemReady ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                w_memto_reg  = 1'b1;
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
                w_next_state = S_FETCH;
            end
            S_MEMWR: begin
                w_iord       = 1'b1;
                w_mem_write  = 1'b1;
                w_instr_done = bus.MemReady;
                w_next_state = bus.MemReady ? S_FETCH : S_MEMWR;
            end
            S_EXECUTE: begin
                w_alu_src_a  = 1'b1;
                w_alu_op     = 2'b10;
                w_next_state = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_dst    = 1'b1;
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
                w_next_state = S_FETCH;
            end
            S_BRANCH: begin
                w_alu_src_a  = 1'b1;
                w_alu_op     = 2'b01;
                w_pc_src     = 2'b01;
                w_branch     = 1'b1;
                w_instr_done = 1'b1;
                w_next_state = S_FETCH;
            end
            S_ADDIEX: begin
                w_alu_src_a  = 1'b1;
                w_alu_src_b  = 2'b10;
                w_next_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
                w_next_state = S_FETCH;
            end
            S_JUMP: begin
                w_pc_src     = 2'b10;
                w_pc_write   = 1'b1;
                w_instr_done = 1'b1;
                w_next_state = S_FETCH;
            end
            default: begin
                // Unreachable codes recover to FETCH with every strobe low
                w_next_state = S_FETCH;
            end
        endcase
    end

    // Output drive; strobes are suppressed while reset is held so nothing
    // is written or requested during an aborted instruction
    always_comb begin
        bus.IorD      = w_iord;
        bus.MemRead   = w_mem_read  & rst_n;
        bus.MemWrite  = w_mem_write & rst_n;
        bus.IRWrite   = w_ir_write  & rst_n;
        bus.RegDst    = w_reg_dst;
        bus.MemtoReg  = w_memto_reg;
        bus.RegWrite  = w_reg_write & rst_n;
        bus.ALUSrcA   = w_alu_src_a;
        bus.ALUSrcB   = w_alu_src_b;
        bus.ALUOp     = w_alu_op;
        bus.PCSrc     = w_pc_src;
        bus.PCEn      = (w_pc_write | (w_branch & bus.Zero)) & rst_n;
        bus.InstrDone = w_instr_done & rst_n;
        bus.IllegalOp = r_illegal;
        bus.State     = r_state;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Moore-style control sequencer for the multicycle MIPS datapath. It replaces single-cycle opcode decoding with a state machine that steps each instruction through fetch, decode, execute, memory and writeback. It drives every datapath mux select and write strobe, and stalls on a memory-ready handshake. It supports R-type, lw, sw, beq, addi and j.

## Interface
Parameters: none.
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- Opcode  in  6  IR[31:26]; stable except in cycles where IRWrite=1
- Zero  in  1  ALU zero flag
- MemReady  in  1  memory completes the current access this cycle
- IorD  out  1  memory address: 0=PC, 1=ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  load instruction register
- RegDst  out  1  write register: 0=rt, 1=rd
- MemtoReg  out  1  write data: 0=ALUOut, 1=MDR
- RegWrite  out  1  register file write strobe
- ALUSrcA  out  1  ALU A: 0=PC, 1=regA
- ALUSrcB  out  2  ALU B: 00=regB, 01=4, 10=SignImm, 11=SignImm<<2
- ALUOp  out  2  to ALU decoder: 00=add, 01=sub, 10=funct
- PCSrc  out  2  PC source: 00=ALUResult, 01=ALUOut, 10=jump target
- PCEn  out  1  PC load enable = PCWrite | (Branch & Zero)
- InstrDone  out  1  one-cycle pulse in the final cycle of each instruction
- IllegalOp  out  1  sticky unsupported-opcode flag
- State  out  4  current state code (debug)

## Operation
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100, addi=001000, j=000010. All others are illegal.
- States and codes, listing the non-zero outputs and the next state. All unlisted outputs are 0.
- FETCH(0): MemRead=1, ALUSrcB=01, IRWrite=PCWrite=MemReady. Goes to DECODE if MemReady, else stays in FETCH.
- DECODE(1): ALUSrcB=11, which precomputes the branch target into ALUOut.
  - lw or sw goes to MEMADR.
  - R goes to EXECUTE.
  - beq goes to BRANCH.
  - addi goes to ADDIEX.
  - j goes to JUMP.
  - Illegal goes to FETCH, sets IllegalOp and pulses InstrDone.
- MEMADR(2): ALUSrcA=1, ALUSrcB=10. lw goes to MEMRD; sw goes to MEMWR.
- MEMRD(3): IorD=1, MemRead=1. Goes to MEMWB if MemReady, else stays.
- MEMWB(4): MemtoReg=1, RegWrite=1, InstrDone=1. Goes to FETCH.
- MEMWR(5): IorD=1, MemWrite=1, held until MemReady. Goes to FETCH with InstrDone=1 when MemReady.
- EXECUTE(6): ALUSrcA=1, ALUOp=10. Goes to ALUWB.
- ALUWB(7): RegDst=1, RegWrite=1, InstrDone=1. Goes to FETCH.
- BRANCH(8): ALUSrcA=1, ALUOp=01, PCSrc=01, Branch=1 (internal), InstrDone=1. Goes to FETCH.
- ADDIEX(9): ALUSrcA=1, ALUSrcB=10. Goes to ADDIWB.
- ADDIWB(10): RegWrite=1, InstrDone=1. Goes to FETCH.
- JUMP(11): PCSrc=10, PCWrite=1, InstrDone=1. Goes to FETCH.
- Codes 12–15 are unreachable. If one is ever entered, the block goes to FETCH next cycle and all strobes are 0.
- IllegalOp is cleared only by reset. Execution continues with the next instruction.

## Timing
- The state register updates on the rising clk edge.
- All outputs are combinational from the state register. The exceptions are:
  - IRWrite and PCWrite, which are additionally gated by MemReady.
  - PCEn, which is additionally gated by Zero.
  - InstrDone in MEMWR, which is gated by MemReady.
- Asynchronous reset (rst_n=0):
  - State=FETCH(0) and IllegalOp=0 immediately.
  - While rst_n=0, IRWrite, PCEn, RegWrite, MemWrite, MemRead and InstrDone are forced to 0.
  - Selects take their FETCH values: ALUSrcB=01, all others 0.
- First FETCH is on the first rising edge after rst_n deasserts.
- Reset mid-instruction aborts it. No partial RegWrite or MemWrite is issued after rst_n falls.
- Latency with MemReady=1 every cycle:
  - lw: 5 cycles
  - sw, R-type, addi: 4 cycles
  - beq, j: 3 cycles
  - illegal: 2 cycles
- Each MemReady=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- Handshake:
  - MemRead and MemWrite are held constant while waiting.
  - The access completes in the cycle where MemReady=1.
  - MemReady is ignored in all other states.
- PCEn in BRANCH follows Zero in that same cycle.

## Test plan
- Reset: hold rst_n=0 with MemReady=1. Expect State=0, ALUSrcB=01, all strobes 0. Release reset. Expect IRWrite=1 and PCEn=1 in the first cycle.
- lw with MemReady=0 for 2 cycles in FETCH and 3 cycles in MEMRD:
  - Expect state sequence 0,0,0,1,2,3,3,3,3,4.
  - Expect RegWrite=1 and MemtoReg=1 only in state 4.
  - Expect InstrDone at cycle 10.
- sw: expect MemWrite=1 and IorD=1 held through the MEMWR wait, and RegWrite=0 throughout.
- beq:
  - With Zero=1 in BRANCH: expect PCEn=1 and PCSrc=01.
  - With Zero=0: expect PCEn=0.
  - Both cases return to FETCH after 3 cycles.
- R-type then addi back-to-back:
  - R-type: ALUWB shows RegDst=1.
  - addi: ADDIWB shows RegDst=0 with ALUSrcB=10 in ADDIEX.
  - Expect InstrDone pulses at cycles 4 and 8.
- Illegal opcode 111111: expect DECODE→FETCH, IllegalOp=1 and staying 1 across a following j. Expect j to assert PCSrc=10 and PCEn=1. Assert reset mid-MEMRD: expect State=0 and IllegalOp=0 immediately.
